// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the board UART transmitter and receiver.
//   uart_tx_state_e   : transmit FSM states
//   UART_DATA_BITS    : data bits per 8N1 frame
//   UART_CLKS_PER_BIT : default design-clock cycles per bit (50 MHz / 115200)
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte stream from the pixel pipeline into the UART.
//   in_data  : byte to transmit
//   in_valid : in_data is valid (driven by the master)
//   in_ready : receiver can accept (driven by the slave)
// A byte moves on any clock edge where in_valid && in_ready.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, reusable by transmitter and receiver.
//   clk, rst_n : clock and synchronous active-low reset (empties the FIFO)
//   push       : write wr_data (ignored while full)
//   wr_data    : write data
//   pop        : discard the head entry (ignored while empty)
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read combinationally so a pop can load it on the same edge.
  assign rd_data = mem[rd_ptr_reg];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffers bytes in a FIFO and sends them as 8N1 frames on txd.
//   clk, rst_n : design clock and synchronous active-low reset
//   in_if      : byte stream in (slave side of uart_tx_if)
//   cts        : host clear-to-send, asynchronous, active-low; sampled only
//                when a frame is about to start
//   txd        : serial line, idle high, registered
//   busy       : frame on the line or bytes still queued
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   in_if,
  input  logic       cts,
  output logic       txd,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  uart_tx_state_e            state_reg, state_next;
  logic [CNT_W-1:0]          baud_reg, baud_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      txd_reg, txd_next;
  logic                      cts_meta_reg, cts_s_reg;
  logic                      ready_reg;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      bit_last, can_start;

  // ready_reg keeps in_ready low through reset and for the release edge.
  assign in_if.in_ready = ready_reg && !fifo_full;
  assign fifo_push      = in_if.in_valid && in_if.in_ready;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (in_if.in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_last  = (baud_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign can_start = !fifo_empty && !cts_s_reg;
  assign txd       = txd_reg;
  assign busy      = (state_reg != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
      cts_meta_reg <= 1'b1;
      cts_s_reg    <= 1'b1;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      txd_reg      <= txd_next;
      cts_meta_reg <= cts;
      cts_s_reg    <= cts_meta_reg;
      ready_reg    <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (can_start) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          state_next = START;
        end
      end
      START: begin
        if (bit_last) begin
          baud_next  = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (idx_reg == IDX_W'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else begin
          baud_next = baud_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          baud_next = '0;
          // Chain straight into the next start bit when another byte may go.
          if (can_start) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // txd is registered from the upcoming state so a pop on edge N
    // drives the start bit from edge N.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus for uart_tx, compared every
// cycle against a frame-timing reference model, with a line decoder that
// recovers bytes from txd.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cts   = 1'b1;
  logic txd;
  logic busy;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (bus),
    .cts   (cts),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bytes plus the position within the frame.
  logic [7:0] q_m[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  bit         active_m;
  int         t_m;
  logic [7:0] byte_m;
  bit         ready_flag_m;
  logic       s1_m, s2_m;

  // Decoder state
  bit         rx_on;
  int         rx_cnt;
  logic [7:0] rx_shift;

  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit can_start;
    if (!rst_n) begin
      q_m.delete();
      exp_q.delete();
      active_m     = 1'b0;
      t_m          = 0;
      ready_flag_m = 1'b0;
      s1_m         = 1'b1;
      s2_m         = 1'b1;
    end else begin
      acc       = bus.in_valid && ready_flag_m && (q_m.size() < DEPTH);
      can_start = (q_m.size() > 0) && (s2_m == 1'b0);
      if (active_m && t_m < FRAME - 1) begin
        t_m++;
      end else if (can_start) begin
        byte_m   = q_m.pop_front();
        active_m = 1'b1;
        t_m      = 0;
      end else begin
        active_m = 1'b0;
      end
      if (acc) begin
        q_m.push_back(bus.in_data);
        exp_q.push_back(bus.in_data);
        $display("push 0x%02h at %0t", bus.in_data, $time);
      end
      s2_m         = s1_m;
      s1_m         = cts;
      ready_flag_m = 1'b1;
    end
    #1;
    check("txd", txd, active_m ? frame_bit(byte_m, t_m) : 1'b1);
    check("in_ready", bus.in_ready, ready_flag_m && (q_m.size() < DEPTH));
    check("busy", busy, active_m || (q_m.size() > 0));

    // Line decoder: samples mid-bit from the first low cycle.
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
        rx_shift[(rx_cnt / CPB) - 1] = txd;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", txd, 1'b1);
        rx_on = 1'b0;
        rx_log.push_back(rx_shift);
        $display("rx 0x%02h at %0t", rx_shift, $time);
        check("rx_byte", {24'h0, rx_shift}, (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD0000);
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit release_cts);
    int stall;
    stall        = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1) begin
      @(negedge clk);
      stall++;
      if (release_cts && stall > 20) cts = 1'b0;
      if (stall > 2000) begin
        check("push_timeout", stall, 0);
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 || rx_on) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check("idle_timeout", n, 0);
        break;
      end
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                           input int n);
    logic [7:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_count"}, rx_log.size(), n);
    for (int i = 0; i < n && i < rx_log.size(); i++)
      check(name, rx_log[i], e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    int n;

    // Reset held with in_valid asserted
    bus.in_data  = 8'hEE;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_txd", txd, 1'b1);
      check("rst_ready", bus.in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1'b1);

    // Single byte 0xA5
    cts = 1'b0;
    repeat (3) @(negedge clk);
    rx_log.delete();
    push(8'hA5, 1'b0);
    check("a5_pre_start", txd, 1'b1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      check("a5_bit", txd, fr[j / CPB]);
    end
    check("a5_busy_stop", busy, 1'b1);
    @(negedge clk);
    check("a5_busy_end", busy, 1'b0);
    wait_idle();
    check_log("a5_rx", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1);

    // Five back-to-back bytes
    rx_log.delete();
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    push(8'h55, 1'b0);
    push(8'h0F, 1'b0);
    push(8'h33, 1'b0);
    wait_idle();
    check_log("b2b_rx", 8'h00, 8'hFF, 8'h55, 8'h0F, 8'h33, 5);

    // Fill the FIFO with the host not ready; the fifth byte waits for a pop
    cts = 1'b1;
    repeat (3) @(negedge clk);
    rx_log.delete();
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b0);
    check("ready_when_full", bus.in_ready, 1'b0);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_stall_ready", bus.in_ready, 1'b0);
    end
    cts = 1'b0;
    n   = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("full_stall_cycles", n, 3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_idle();
    check_log("full_rx", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 5);

    // Flow control
    cts = 1'b1;
    repeat (3) @(negedge clk);
    rx_log.delete();
    push(8'h3C, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("cts_hold_txd", txd, 1'b1);
      check("cts_hold_busy", busy, 1'b1);
    end
    cts = 1'b0;
    n   = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cts_start_latency", n, 3);
    repeat (12) @(negedge clk);
    cts = 1'b1;
    wait_idle();
    check_log("cts_rx", 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1);

    // Reset during data bit 3 of 0x81
    cts = 1'b0;
    repeat (3) @(negedge clk);
    rx_log.delete();
    push(8'h81, 1'b0);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * CPB + 1) @(negedge clk);
    check("bit3_level", txd, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_txd", txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      check("post_rst_txd", txd, 1'b1);
    end
    check("post_rst_rx_count", rx_log.size(), 0);

    // Randomized traffic with random flow control
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) cts = ~cts;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push(8'($urandom_range(0, 255)), 1'b1);
    end
    cts = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle();
    check("all_delivered", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
